// File: rtl/mem_xbar_n.sv
// Registered 1-master to N-slave address-decoding interconnect on the native valid/ready memory bus.
// Optional slave response timeout is enabled by defining MEM_XBAR_TIMEOUT_EN.
module mem_xbar_n #(
    parameter int NUM_SLAVES = 7,
    parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRS = {32'h40000000, 32'h38000000, 32'h30000000,
                                                      32'h28000000, 32'h20000000, 32'h10000000,
                                                      32'h00000000},
    parameter logic [32*NUM_SLAVES-1:0] ADDR_MASKS = {32'h40000000, 32'h78000000, 32'h78000000,
                                                      32'h78000000, 32'h78000000, 32'h70000000,
                                                      32'h70000000},
    parameter logic [31:0] DECERR_DATA = 32'hDEADBEEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_mem_valid,
    output logic                     s_mem_ready,
    input  logic [31:0]              s_mem_addr,
    input  logic [31:0]              s_mem_wdata,
    input  logic [3:0]               s_mem_wstrb,
    output logic [31:0]              s_mem_rdata,
    output logic [NUM_SLAVES-1:0]    m_mem_valid,
    input  logic [NUM_SLAVES-1:0]    m_mem_ready,
    output logic [31:0]              m_mem_addr,
    output logic [31:0]              m_mem_wdata,
    output logic [3:0]               m_mem_wstrb,
    input  logic [32*NUM_SLAVES-1:0] m_mem_rdata,
    output logic                     err_pulse,
    output logic [31:0]              err_addr,
    output logic                     err_timeout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t                  state;
    logic [NUM_SLAVES-1:0]   hit_oh;
    logic                    hit;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("mem_xbar_n: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES at least 1");
        end
    endgenerate

    // Scanning from the top down lets the lowest hitting index overwrite the others.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit_oh = '0;
        hit    = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((s_mem_addr & ADDR_MASKS[32*i +: 32]) == (BASE_ADDRS[32*i +: 32] & ADDR_MASKS[32*i +: 32])) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // m_mem_valid doubles as the latched one-hot select while in ACCESS.
    always_comb begin
        sel_ready = |(m_mem_valid & m_mem_ready);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_rdata = sel_rdata | ({32{m_mem_valid[i]}} & m_mem_rdata[32*i +: 32]);
        end
    end

`ifdef MEM_XBAR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
`else
    assign err_timeout = 1'b0;
`endif

    // NOTE: all state here is sequential, so it uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            m_mem_valid <= '0;
            s_mem_ready <= 1'b0;
            s_mem_rdata <= '0;
            m_mem_addr  <= '0;
            m_mem_wdata <= '0;
            m_mem_wstrb <= '0;
            err_pulse   <= 1'b0;
            err_addr    <= '0;
`ifdef MEM_XBAR_TIMEOUT_EN
            err_timeout <= 1'b0;
            cnt         <= '0;
            timeout_hit <= 1'b0;
`endif
        end else begin
            s_mem_ready <= 1'b0;
            err_pulse   <= 1'b0;
            case (state)
                IDLE: begin
                    // The master still holds valid while it sees the ready pulse; do not re-accept it.
                    if (s_mem_valid && !s_mem_ready) begin
                        m_mem_addr  <= s_mem_addr;
                        m_mem_wdata <= s_mem_wdata;
                        m_mem_wstrb <= s_mem_wstrb;
`ifdef MEM_XBAR_TIMEOUT_EN
                        cnt         <= '0;
                        timeout_hit <= 1'b0;
`endif
                        if (hit) begin
                            m_mem_valid <= hit_oh;
                            state       <= ACCESS;
                        end else begin
                            state       <= ERR;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        s_mem_rdata <= sel_rdata;
                        m_mem_valid <= '0;
                        state       <= RESP;
`ifdef MEM_XBAR_TIMEOUT_EN
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        m_mem_valid <= '0;
                        timeout_hit <= 1'b1;
                        state       <= ERR;
                    end else begin
                        cnt         <= cnt + CNT_W'(1);
`endif
                    end
                end
                RESP: begin
                    s_mem_ready <= 1'b1;
                    state       <= IDLE;
                end
                ERR: begin
                    s_mem_ready <= 1'b1;
                    s_mem_rdata <= DECERR_DATA;
                    err_pulse   <= 1'b1;
                    err_addr    <= m_mem_addr;
`ifdef MEM_XBAR_TIMEOUT_EN
                    err_timeout <= timeout_hit;
`endif
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_xbar_n.sv
// Directed testbench for mem_xbar_n: default seven-slave map plus a two-slave map for decode errors.
module tb_mem_xbar_n;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0;
    logic         s2_valid = 1'b0;
    logic [31:0]  s_addr = '0;
    logic [31:0]  s_wdata = '0;
    logic [3:0]   s_wstrb = '0;

    logic         s_ready, err_pulse, err_timeout;
    logic [31:0]  s_rdata, m_addr, m_wdata, err_addr;
    logic [3:0]   m_wstrb;
    logic [6:0]   m_valid;
    logic [6:0]   m_ready = '0;
    logic [223:0] m_rdata = '0;

    logic         s2_ready, err2_pulse, err2_timeout;
    logic [31:0]  s2_rdata, m2_addr, m2_wdata, err2_addr;
    logic [3:0]   m2_wstrb;
    logic [1:0]   m2_valid;
    logic [1:0]   m2_ready = '0;
    logic [63:0]  m2_rdata = {32'h22222222, 32'h11111111};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_xbar_n #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk(clk), .rst(rst),
        .s_mem_valid(s_valid), .s_mem_ready(s_ready), .s_mem_addr(s_addr),
        .s_mem_wdata(s_wdata), .s_mem_wstrb(s_wstrb), .s_mem_rdata(s_rdata),
        .m_mem_valid(m_valid), .m_mem_ready(m_ready), .m_mem_addr(m_addr),
        .m_mem_wdata(m_wdata), .m_mem_wstrb(m_wstrb), .m_mem_rdata(m_rdata),
        .err_pulse(err_pulse), .err_addr(err_addr), .err_timeout(err_timeout)
    );

    mem_xbar_n #(
        .NUM_SLAVES(2),
        .BASE_ADDRS({32'h10000000, 32'h00000000}),
        .ADDR_MASKS({32'hF0000000, 32'hF0000000})
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .s_mem_valid(s2_valid), .s_mem_ready(s2_ready), .s_mem_addr(s_addr),
        .s_mem_wdata(s_wdata), .s_mem_wstrb(s_wstrb), .s_mem_rdata(s2_rdata),
        .m_mem_valid(m2_valid), .m_mem_ready(m2_ready), .m_mem_addr(m2_addr),
        .m_mem_wdata(m2_wdata), .m_mem_wstrb(m2_wstrb), .m_mem_rdata(m2_rdata),
        .err_pulse(err2_pulse), .err_addr(err2_addr), .err_timeout(err2_timeout)
    );

    // At most one slave request may be active at any time.
    always @(negedge clk) begin
        vectors++;
        if (!$onehot0(m_valid)) begin
            miscompares++;
            $display("FAIL onehot: m_mem_valid=%b required at most one bit set", m_valid);
        end
    end

    // Master/slave driver: slave slv raises ready so it is sampled at edge k (k=0: never).
    task automatic run_txn(input int slv, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input int k, input logic [31:0] rd,
                           input logic [6:0] noise,
                           output logic [6:0] v0, output logic [31:0] a0, output logic [31:0] wd0,
                           output logic [3:0] ws0, output int lat, output logic [31:0] rd_o,
                           output int plen, output logic ep, output logic reaccept);
        for (int i = 0; i < 7; i++) m_rdata[32*i +: 32] = 32'h0BAD0000 | i;
        m_rdata[32*slv +: 32] = rd;
        lat = 0; plen = 0; rd_o = '0; ep = 1'b0; reaccept = 1'b0;
        @(negedge clk);
        s_addr = a; s_wdata = wd; s_wstrb = ws; s_valid = 1'b1; m_ready = noise;
        @(posedge clk); #1;
        v0 = m_valid; a0 = m_addr; wd0 = m_wdata; ws0 = m_wstrb;
        if (k == 1) m_ready[slv] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == k) m_ready[slv] = 1'b0;
            if (n == k - 1) m_ready[slv] = 1'b1;
            if (s_ready) begin
                if (lat == 0) begin
                    lat = n; rd_o = s_rdata; ep = err_pulse;
                end
                plen++;
            end
            if (lat != 0 && n == lat + 1) begin
                reaccept = (m_valid != '0);
                s_valid = 1'b0;
            end
            if (lat != 0 && n == lat + 2) break;
        end
        m_ready = '0;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        vectors++; if (s_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_s_rdata: got %h want 0", s_rdata); end
        vectors++; if (m_valid !== 7'h0) begin miscompares++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        vectors++; if ({m_addr, m_wdata, m_wstrb} !== 68'h0) begin miscompares++; $display("FAIL rst_m_bus: got %h %h %h want 0", m_addr, m_wdata, m_wstrb); end
        vectors++; if ({err_pulse, err_addr, err_timeout} !== 34'h0) begin miscompares++; $display("FAIL rst_err: got %b %h %b want 0", err_pulse, err_addr, err_timeout); end
        vectors++; if ({s2_ready, m2_valid, err2_pulse} !== 4'h0) begin miscompares++; $display("FAIL rst_dut2: got %b %b %b want 0", s2_ready, m2_valid, err2_pulse); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_read_slave1();
        logic [6:0] v0; logic [31:0] a0, wd0, rd_o; logic [3:0] ws0; int lat, plen; logic ep, ra;
        run_txn(1, 32'h10000004, 32'h0, 4'b0000, 3, 32'h12345678, 7'h0, v0, a0, wd0, ws0, lat, rd_o, plen, ep, ra);
        vectors++; if (v0 !== 7'b0000010) begin miscompares++; $display("FAIL rd1_valid: got %b want 0000010", v0); end
        vectors++; if (a0 !== 32'h10000004) begin miscompares++; $display("FAIL rd1_addr: got %h want 10000004", a0); end
        vectors++; if (ws0 !== 4'b0000) begin miscompares++; $display("FAIL rd1_wstrb: got %b want 0000", ws0); end
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rd1_latency: got %0d want 4", lat); end
        vectors++; if (rd_o !== 32'h12345678) begin miscompares++; $display("FAIL rd1_rdata: got %h want 12345678", rd_o); end
        vectors++; if (plen !== 1) begin miscompares++; $display("FAIL rd1_pulse_len: got %0d want 1", plen); end
        vectors++; if (ep !== 1'b0) begin miscompares++; $display("FAIL rd1_err_pulse: got %b want 0", ep); end
        vectors++; if (ra !== 1'b0) begin miscompares++; $display("FAIL rd1_reaccept: got %b want 0", ra); end
        repeat (3) @(posedge clk); #1;
        vectors++; if (s_rdata !== 32'h12345678) begin miscompares++; $display("FAIL rd1_rdata_hold: got %h want 12345678", s_rdata); end
    endtask

    task automatic test_write_slave5();
        logic [6:0] v0; logic [31:0] a0, wd0, rd_o; logic [3:0] ws0; int lat, plen; logic ep, ra;
        run_txn(5, 32'h38000010, 32'hA5A5A5A5, 4'b0011, 1, 32'h5A5A0005, 7'h0, v0, a0, wd0, ws0, lat, rd_o, plen, ep, ra);
        vectors++; if (v0 !== 7'b0100000) begin miscompares++; $display("FAIL wr5_valid: got %b want 0100000", v0); end
        vectors++; if (a0 !== 32'h38000010) begin miscompares++; $display("FAIL wr5_addr: got %h want 38000010", a0); end
        vectors++; if (wd0 !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL wr5_wdata: got %h want a5a5a5a5", wd0); end
        vectors++; if (ws0 !== 4'b0011) begin miscompares++; $display("FAIL wr5_wstrb: got %b want 0011", ws0); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr5_latency: got %0d want 2", lat); end
        vectors++; if (rd_o !== 32'h5A5A0005) begin miscompares++; $display("FAIL wr5_rdata: got %h want 5a5a0005", rd_o); end
        vectors++; if (plen !== 1) begin miscompares++; $display("FAIL wr5_pulse_len: got %0d want 1", plen); end
    endtask

    task automatic test_decode_error();
        int lat = 0; logic any_valid = 1'b0; logic [31:0] rd = '0, ea = '0; logic ep = 1'b0, et = 1'b1;
        @(negedge clk);
        s_addr = 32'h50000000; s_wstrb = 4'b0000; s2_valid = 1'b1; m2_ready = 2'b11;
        @(posedge clk); #1;
        any_valid = (m2_valid != '0);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (m2_valid != '0) any_valid = 1'b1;
            if (s2_ready && lat == 0) begin
                lat = n; rd = s2_rdata; ep = err2_pulse; ea = err2_addr; et = err2_timeout;
            end
            if (lat != 0 && n == lat + 1) begin
                s2_valid = 1'b0;
                vectors++; if (err2_pulse !== 1'b0 || s2_ready !== 1'b0) begin miscompares++; $display("FAIL de_pulse_len: got %b/%b want 0/0", err2_pulse, s2_ready); end
                break;
            end
        end
        s2_valid = 1'b0; m2_ready = '0;
        vectors++; if (any_valid !== 1'b0) begin miscompares++; $display("FAIL de_no_valid: got %b want 0", any_valid); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL de_latency: got %0d want 1", lat); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL de_rdata: got %h want deadbeef", rd); end
        vectors++; if (ep !== 1'b1) begin miscompares++; $display("FAIL de_err_pulse: got %b want 1", ep); end
        vectors++; if (ea !== 32'h50000000) begin miscompares++; $display("FAIL de_err_addr: got %h want 50000000", ea); end
        vectors++; if (et !== 1'b0) begin miscompares++; $display("FAIL de_err_timeout: got %b want 0", et); end
    endtask

    task automatic test_priority();
        logic [6:0] v0; logic [31:0] a0, wd0, rd_o; logic [3:0] ws0; int lat, plen; logic ep, ra;
        run_txn(6, 32'h40000000, 32'h0, 4'b0000, 2, 32'h66666666, 7'b0000001, v0, a0, wd0, ws0, lat, rd_o, plen, ep, ra);
        vectors++; if (v0 !== 7'b1000000) begin miscompares++; $display("FAIL pri_valid: got %b want 1000000", v0); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL pri_latency: got %0d want 3", lat); end
        vectors++; if (rd_o !== 32'h66666666) begin miscompares++; $display("FAIL pri_rdata: got %h want 66666666", rd_o); end
    endtask

    task automatic test_timeout();
        logic [6:0] v0; logic [31:0] a0, wd0, rd_o; logic [3:0] ws0; int lat, plen; logic ep, ra;
        int drop = 0; int tlat = 0; logic [31:0] rd = '0, ea = '0; logic et = 1'b0, tp = 1'b0;
        m_rdata[95:64] = 32'h22220002;
        @(negedge clk);
        s_addr = 32'h20000100; s_wstrb = 4'b0000; s_valid = 1'b1;
        @(posedge clk); #1;
        vectors++; if (m_valid !== 7'b0000100) begin miscompares++; $display("FAIL to_valid: got %b want 0000100", m_valid); end
`ifdef MEM_XBAR_TIMEOUT_EN
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            if (m_valid == '0 && drop == 0) drop = n;
            if (s_ready && tlat == 0) begin
                tlat = n; rd = s_rdata; et = err_timeout; tp = err_pulse; ea = err_addr;
            end
            if (tlat != 0) break;
        end
        s_valid = 1'b0;
        vectors++; if (drop !== 8) begin miscompares++; $display("FAIL to_drop_edge: got %0d want 8", drop); end
        vectors++; if (tlat !== 9) begin miscompares++; $display("FAIL to_latency: got %0d want 9", tlat); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL to_rdata: got %h want deadbeef", rd); end
        vectors++; if (et !== 1'b1) begin miscompares++; $display("FAIL to_err_timeout: got %b want 1", et); end
        vectors++; if (tp !== 1'b1) begin miscompares++; $display("FAIL to_err_pulse: got %b want 1", tp); end
        vectors++; if (ea !== 32'h20000100) begin miscompares++; $display("FAIL to_err_addr: got %h want 20000100", ea); end
`else
        repeat (20) begin
            @(posedge clk); #1;
            if (s_ready) tlat = 1;
        end
        vectors++; if (m_valid !== 7'b0000100 || tlat !== 0) begin miscompares++; $display("FAIL to_wait: got valid %b ready_seen %0d want 0000100 0", m_valid, tlat); end
        m_ready[2] = 1'b1;
        @(posedge clk); #1; m_ready[2] = 1'b0;
        @(posedge clk); #1;
        vectors++; if (s_ready !== 1'b1 || s_rdata !== 32'h22220002) begin miscompares++; $display("FAIL to_late_resp: got %b %h want 1 22220002", s_ready, s_rdata); end
        vectors++; if (err_timeout !== 1'b0 || err_pulse !== 1'b0) begin miscompares++; $display("FAIL to_no_err: got %b %b want 0 0", err_timeout, err_pulse); end
        s_valid = 1'b0;
`endif
        repeat (2) @(posedge clk);
        // Ready on the last allowed cycle wins over the timeout.
        run_txn(2, 32'h20000100, 32'h0, 4'b0000, 8, 32'h22220002, 7'h0, v0, a0, wd0, ws0, lat, rd_o, plen, ep, ra);
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL tie_latency: got %0d want 9", lat); end
        vectors++; if (rd_o !== 32'h22220002 || ep !== 1'b0) begin miscompares++; $display("FAIL tie_resp: got %h err %b want 22220002 err 0", rd_o, ep); end
    endtask

    task automatic test_reset_in_access();
        logic [6:0] v0; logic [31:0] a0, wd0, rd_o; logic [3:0] ws0; int lat, plen; logic ep, ra;
        @(negedge clk);
        s_addr = 32'h28000000; s_wdata = 32'h11112222; s_wstrb = 4'b1111; s_valid = 1'b1;
        @(posedge clk); #1;
        vectors++; if (m_valid !== 7'b0001000) begin miscompares++; $display("FAIL ra_pre_valid: got %b want 0001000", m_valid); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        vectors++; if (m_valid !== 7'h0 || s_ready !== 1'b0) begin miscompares++; $display("FAIL ra_valid_ready: got %b %b want 0 0", m_valid, s_ready); end
        vectors++; if (s_rdata !== 32'h0) begin miscompares++; $display("FAIL ra_rdata: got %h want 0", s_rdata); end
        vectors++; if ({m_addr, m_wdata, m_wstrb} !== 68'h0) begin miscompares++; $display("FAIL ra_m_bus: got %h %h %h want 0", m_addr, m_wdata, m_wstrb); end
        vectors++; if ({err_pulse, err_addr, err_timeout} !== 34'h0) begin miscompares++; $display("FAIL ra_err: got %b %h %b want 0", err_pulse, err_addr, err_timeout); end
        vectors++; if (err2_addr !== 32'h0) begin miscompares++; $display("FAIL ra_err2_addr: got %h want 0", err2_addr); end
        @(negedge clk);
        s_valid = 1'b0; rst = 1'b0;
        run_txn(3, 32'h28000000, 32'h0, 4'b0000, 1, 32'h33330003, 7'h0, v0, a0, wd0, ws0, lat, rd_o, plen, ep, ra);
        vectors++; if (v0 !== 7'b0001000) begin miscompares++; $display("FAIL ra_post_valid: got %b want 0001000", v0); end
        vectors++; if (lat !== 2 || rd_o !== 32'h33330003) begin miscompares++; $display("FAIL ra_post_resp: got lat %0d %h want 2 33330003", lat, rd_o); end
    endtask

    initial begin
        test_reset();
        test_read_slave1();
        test_write_slave5();
        test_decode_error();
        test_priority();
        test_timeout();
        test_reset_in_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
